// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 6-digit 7-segment scan into a BCD time value.
// Digits are debounced, range-checked and published only as complete frames.
module seg_scan_decoder #(
  parameter int STABLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [23:0] time_bcd,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        scan_lost
);

  localparam logic [3:0]  STABLE_C = 4'(STABLE);
  localparam logic [15:0] TMO_C    = 16'(TIMEOUT);

  logic [7:0]  com_q, data_q, com_p, data_p;
  logic [3:0]  stab_cnt, stab_nxt;
  logic        changed, hit;
  logic        idx_ok, pat_ok, range_ok;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic        acc_q, acc_good;
  logic [2:0]  acc_idx;
  logic [3:0]  acc_digit;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic [5:0]  mask, mask_base, mask_nxt;
  logic [3:0]  shadow [6];

  always_comb begin
    idx_ok = 1'b1;
    idx    = 3'd0;
    case (com_q)
      8'h7F:   idx = 3'd0;
      8'hBF:   idx = 3'd1;
      8'hDF:   idx = 3'd2;
      8'hEF:   idx = 3'd3;
      8'hF7:   idx = 3'd4;
      8'hFB:   idx = 3'd5;
      default: idx_ok = 1'b0;
    endcase
  end

  // dp (bit 0) is don't-care
  always_comb begin
    pat_ok = 1'b1;
    digit  = 4'd0;
    case (data_q[7:1])
      7'h7E:   digit = 4'd0;
      7'h30:   digit = 4'd1;
      7'h6D:   digit = 4'd2;
      7'h79:   digit = 4'd3;
      7'h33:   digit = 4'd4;
      7'h5B:   digit = 4'd5;
      7'h5F:   digit = 4'd6;
      7'h72:   digit = 4'd7;
      7'h7F:   digit = 4'd8;
      7'h7B:   digit = 4'd9;
      default: pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    range_ok = 1'b1;
    if ((idx == 3'd1 || idx == 3'd3) && digit > 4'd5) range_ok = 1'b0;
    if (idx == 3'd5 && digit > 4'd2)                   range_ok = 1'b0;
  end

  // Accept fires only on the transition into STABLE, so a held digit is taken once
  always_comb begin
    changed = {com_q, data_q} != {com_p, data_p};
    if (!idx_ok)                  stab_nxt = 4'd0;
    else if (changed)             stab_nxt = 4'd1;
    else if (stab_cnt >= STABLE_C) stab_nxt = STABLE_C;
    else                          stab_nxt = stab_cnt + 4'd1;
    hit = idx_ok && (stab_nxt == STABLE_C) && (changed || stab_cnt != STABLE_C);
  end

  always_comb begin
    tmo_nxt   = acc_q ? 16'd0 : ((tmo_cnt == TMO_C) ? TMO_C : tmo_cnt + 16'd1);
    mask_base = (mask == 6'h3F) ? 6'h00 : mask;
    if (acc_q)                 mask_nxt = acc_good ? (mask_base | (6'd1 << acc_idx)) : 6'h00;
    else if (tmo_nxt == TMO_C) mask_nxt = 6'h00;
    else                       mask_nxt = mask_base;
  end

  assign scan_lost = (tmo_cnt == TMO_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      com_q       <= 8'hFF;
      data_q      <= 8'h00;
      com_p       <= 8'hFF;
      data_p      <= 8'h00;
      stab_cnt    <= 4'd0;
      acc_q       <= 1'b0;
      acc_good    <= 1'b0;
      acc_idx     <= 3'd0;
      acc_digit   <= 4'd0;
      tmo_cnt     <= 16'd0;
      mask        <= 6'h00;
      time_bcd    <= 24'h000000;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= 4'd0;
    end else begin
      com_q       <= seg_com;
      data_q      <= seg_data;
      com_p       <= com_q;
      data_p      <= data_q;
      stab_cnt    <= stab_nxt;
      // Latch the decode with the accept: the input register moves on next edge
      acc_q       <= hit;
      acc_good    <= pat_ok && range_ok;
      acc_idx     <= idx;
      acc_digit   <= digit;
      tmo_cnt     <= tmo_nxt;
      mask        <= mask_nxt;
      seg_err     <= acc_q && !acc_good;
      frame_valid <= (mask == 6'h3F);
      if (mask == 6'h3F)
        time_bcd <= {shadow[5], shadow[4], shadow[3], shadow[2], shadow[1], shadow[0]};
      if (acc_q && acc_good)
        shadow[acc_idx] <= acc_digit;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frame/error
// events, a forked monitor pops them whenever the DUT pulses an output.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_com, seg_data;
  logic [23:0] time_bcd;
  logic        frame_valid, seg_err, scan_lost;

  int n_pass, n_total;

  typedef struct {
    bit          is_err;
    logic [23:0] val;
  } exp_t;
  exp_t q[$];

  seg_scan_decoder #(.STABLE(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .seg_com(seg_com), .seg_data(seg_data),
    .time_bcd(time_bcd), .frame_valid(frame_valid), .seg_err(seg_err),
    .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 8'hFC;  4'd1: return 8'h60;  4'd2: return 8'hDA;
      4'd3: return 8'hF2;  4'd4: return 8'h66;  4'd5: return 8'hB6;
      4'd6: return 8'hBE;  4'd7: return 8'hE4;  4'd8: return 8'hFE;
      default: return 8'hF6;
    endcase
  endfunction

  function automatic logic [7:0] com_of(input int k);
    case (k)
      0: return 8'h7F;  1: return 8'hBF;  2: return 8'hDF;
      3: return 8'hEF;  4: return 8'hF7;  default: return 8'hFB;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit is_err, input logic [23:0] v);
    exp_t e;
    e.is_err = is_err;
    e.val    = v;
    q.push_back(e);
  endtask

  // Called at a falling edge; leaves the caller at a falling edge.
  task automatic hold(input logic [7:0] com, input logic [7:0] data, input int n);
    seg_com  = com;
    seg_data = data;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [23:0] t, input int start, input bit glitch);
    for (int i = 0; i < 6; i++) begin
      int k;
      logic [3:0] d;
      k = (start + i) % 6;
      d = t[4*k +: 4];
      if (glitch) hold(com_of(k), 8'h00, 1);
      hold(com_of(k), seg_pat(d), 4);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (frame_valid || seg_err)) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: got frame_valid=%b seg_err=%b time_bcd=%h expected none",
                   frame_valid, seg_err, time_bcd);
        end else begin
          e = q.pop_front();
          chk("event_is_err", 32'(seg_err), 32'(e.is_err));
          if (!e.is_err) chk("frame_time_bcd", 32'(time_bcd), 32'(e.val));
        end
      end
    end
  endtask

  initial begin
    int rise;
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    seg_com  = 8'hFF;
    seg_data = 8'h00;
    fork
      monitor();
      begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_time_bcd", 32'(time_bcd), 32'h0);
    chk("reset_frame_valid", 32'(frame_valid), 32'h0);
    chk("reset_seg_err", 32'(seg_err), 32'h0);
    chk("reset_scan_lost", 32'(scan_lost), 32'h0);
    rst = 1'b0;

    // Full scan of 12:34:56
    push(1'b0, 24'h123456);
    scan(24'h123456, 0, 1'b0);
    hold(8'hFF, 8'h00, 8);
    chk("time_after_scan", 32'(time_bcd), 32'h123456);

    // Four digits, s10=7 error, then s1/s10: mask was cleared so no frame
    hold(com_of(5), seg_pat(4'd1), 4);
    hold(com_of(4), seg_pat(4'd2), 4);
    hold(com_of(3), seg_pat(4'd3), 4);
    hold(com_of(2), seg_pat(4'd4), 4);
    push(1'b1, 24'h0);
    hold(com_of(1), 8'hE4, 4);
    hold(com_of(0), seg_pat(4'd6), 4);
    hold(com_of(1), seg_pat(4'd5), 4);
    push(1'b1, 24'h0);
    hold(com_of(5), seg_pat(4'd3), 4);
    hold(8'hFF, 8'h00, 4);
    chk("time_after_errors", 32'(time_bcd), 32'h123456);

    // s1 invalid pattern, then idle scan: timeout reached 64 cycles after that accept
    push(1'b1, 24'h0);
    hold(com_of(0), 8'h00, 4);
    seg_com  = 8'hFF;
    seg_data = 8'h00;
    rise = 0;
    for (int k = 5; k <= 104; k++) begin
      @(negedge clk);
      if (scan_lost && rise == 0) rise = k;
    end
    chk("scan_lost_rise_cycle", 32'(rise), 32'd68);
    chk("scan_lost_held", 32'(scan_lost), 32'h1);
    seg_com  = com_of(0);
    seg_data = seg_pat(4'd5);
    repeat (3) @(negedge clk);
    chk("scan_lost_before_drop", 32'(scan_lost), 32'h1);
    @(negedge clk);
    chk("scan_lost_after_accept", 32'(scan_lost), 32'h0);
    @(negedge clk);

    // Glitched scan: one-cycle invalid pattern before each digit
    push(1'b0, 24'h123456);
    scan(24'h123456, 0, 1'b1);
    hold(8'hFF, 8'h00, 8);

    // Reset after three digits, then a scan starting at m10
    hold(com_of(0), seg_pat(4'd9), 4);
    hold(com_of(1), seg_pat(4'd4), 4);
    hold(com_of(2), seg_pat(4'd8), 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_time_bcd", 32'(time_bcd), 32'h0);
    chk("midreset_scan_lost", 32'(scan_lost), 32'h0);
    rst = 1'b0;
    push(1'b0, 24'h235959);
    scan(24'h235959, 3, 1'b0);
    hold(8'hFF, 8'h00, 8);

    // Continuous scanning of an unchanging time
    push(1'b0, 24'h235959);
    push(1'b0, 24'h235959);
    scan(24'h235959, 0, 1'b0);
    scan(24'h235959, 0, 1'b0);
    hold(8'hFF, 8'h00, 10);
    chk("time_after_continuous", 32'(time_bcd), 32'h235959);
    chk("pending_expected_events", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
